stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Timekeeping engine of the stopwatch/timer, fed directly by the debounced single-cycle button pulses and switch levels from the input-conditioning stage. It holds the mm:ss value as four BCD digits, runs the start/stop/pause control FSM and counts up (stopwatch) or down (timer). Its digit outputs feed the seven-segment scan/multiplex stage that drives seg/an.

Parameters:
TICKS_PER_SEC, 25_000_000, clk cycles per counted second (25 MHz system clock); benches use 4.
MAX_MIN, 99, highest minute value; minutes wrap MAX_MIN->0.

Ports:
clk  input  1  system clock, 25 MHz
rst  input  1  asynchronous, active-high reset
en  input  1  global enable; low freezes prescaler and ignores all pulses except softrst
start_p  input  1  debounced start pulse, one cycle wide
stop_p  input  1  debounced stop pulse, one cycle wide
softrst  input  1  debounced soft-reset switch level
inc_min_p  input  1  debounced minute-increment pulse
inc_sec_p  input  1  debounced second-increment pulse
inc_sw  input  1  count direction: 0 up (stopwatch), 1 down (timer)
min_tens  output  4  BCD 0-9
min_ones  output  4  BCD 0-9
sec_tens  output  4  BCD 0-5
sec_ones  output  4  BCD 0-9
running  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (rst high, async): all digits 0, prescaler 0, state IDLE, dir 0, running 0, done 0. Held while rst high.
- All outputs registered; input event at edge N is visible after edge N+1 (1-cycle latency).
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: start_p -> RUN, latch dir<=inc_sw, prescaler<=0. Exception: dir would be 1 and time 00:00 -> stay IDLE.
- RUN: stop_p -> PAUSE (prescaler holds value). Tick when prescaler==TICKS_PER_SEC-1 and en; prescaler then reloads 0.
- PAUSE: start_p -> RUN, dir re-latched from inc_sw, prescaler continues from held value. Same 00:00/down exception keeps PAUSE.
- DONE: entered only in down mode when a tick takes time 00:01 -> 00:00. start_p, stop_p, inc pulses ignored; only softrst or rst leave it.
- inc_sw changes while in RUN have no effect until the next start.
- Up tick: sec +1; 59->00 with carry into minutes; MAX_MIN:59 -> 00:00, stays RUN.
- Down tick: sec -1; 00->59 with borrow from minutes.
- inc_sec_p: only in IDLE/PAUSE; sec +1, 59->00, no carry. inc_min_p: only in IDLE/PAUSE; min +1, MAX_MIN->00. Both in the same cycle: both applied. Ignored in RUN/DONE.
- softrst high (any state, en ignored): next edge digits 00:00, prescaler 0, state IDLE. Held while high; all pulses ignored while high.
- Priority when simultaneous: rst > softrst > stop_p > start_p > increments. start_p+stop_p in RUN -> PAUSE; in PAUSE -> stays PAUSE.
- en low: prescaler frozen, no ticks, start/stop/inc ignored, state held.
- Digits never leave legal BCD range. Minute arithmetic on two BCD digits, no binary conversion.

Decomposition:
- stopwatch_pkg: state enum (IDLE, RUN, PAUSE, DONE), bcd_t (logic [3:0]), SEC_MAX=59, digit constants.
- Sub-module bcd2_counter: two-digit BCD up/down counter. Parameterized modulus (60 or MAX_MIN+1). Ports inc, dec, clr, carry_out, borrow_out. Instantiated twice (seconds, minutes). Top holds FSM and prescaler.

Test Plan (TICKS_PER_SEC=4):
1. Assert rst mid-RUN at 01:23 -> digits 0000, running=0, done=0 immediately (async); state IDLE after release.
2. IDLE, inc_min_p x2, inc_sec_p x3 -> 02:03. Then preset sec 59 + inc_sec_p -> 02:00, minutes unchanged. Simultaneous inc_min_p+inc_sec_p at 02:00 -> 03:01.
3. inc_sw=0, start_p at 00:00, run 244 cycles -> 01:01, running=1. stop_p -> holds 01:01 for 40 cycles. start_p -> counting resumes, next tick after remaining prescaler count.
4. Preset 00:02, inc_sw=1, start_p, 8 cycles -> 00:00, done=1, running=0. start_p in DONE ignored. softrst -> IDLE, done=0. Start at 00:00 down mode -> stays IDLE.
5. In RUN, start_p+stop_p same cycle -> PAUSE. softrst during RUN at 00:45 -> 00:00, IDLE next edge. inc_sec_p in RUN -> no change.
6. Preset 99:59 up mode, run 4 cycles -> 00:00, still RUN. en=0 for 20 cycles -> time and prescaler frozen, start/stop pulses ignored.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch core
//
// Purpose: control-FSM state encoding, BCD digit type and the seconds modulus
// shared by stopwatch_core and bcd2_counter.
// Ports: none (package).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int   SEC_MAX  = 59;
  localparam int   SEC_MOD  = SEC_MAX + 1;
  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_ONE  = 4'd1;
  localparam bcd_t BCD_NINE = 4'd9;

  // Tens digit of the largest value a counter of modulus m can hold.
  function automatic bcd_t max_tens(input int m);
    return bcd_t'((m - 1) / 10);
  endfunction

  // Ones digit of the largest value a counter of modulus m can hold.
  function automatic bcd_t max_ones(input int m);
    return bcd_t'((m - 1) % 10);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD up/down counter with wrap
//
// Purpose: holds one two-digit BCD field (seconds or minutes) and steps it
// up or down, wrapping at the modulus without any binary conversion.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous clear to 00 (highest priority)
//   inc, dec        step up / down by one (inc wins if both)
//   tens, ones      registered BCD digits
//   carry_out       inc while at the maximum value (wrap to 00)
//   borrow_out      dec while at 00 (wrap to the maximum value)
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out,
  output logic       borrow_out
);

  localparam bcd_t MAX_T = max_tens(MOD);
  localparam bcd_t MAX_O = max_ones(MOD);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_max, at_zero;

  assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign at_zero = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);

  // Combinational so the neighbouring field can step in the same cycle.
  assign carry_out  = inc && !clr && at_max;
  assign borrow_out = dec && !inc && !clr && at_zero;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = BCD_ZERO;
      ones_d = BCD_ZERO;
    end else if (inc) begin
      if (at_max) begin
        tens_d = BCD_ZERO;
        ones_d = BCD_ZERO;
      end else if (ones_q == BCD_NINE) begin
        tens_d = tens_q + 4'd1;
        ones_d = BCD_ZERO;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens_d = MAX_T;
        ones_d = MAX_O;
      end else if (ones_q == BCD_ZERO) begin
        tens_d = tens_q - 4'd1;
        ones_d = BCD_NINE;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= BCD_ZERO;
      ones_q <= BCD_ZERO;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - mm:ss stopwatch/timer engine with control FSM
//
// Purpose: runs the IDLE/RUN/PAUSE/DONE control FSM, the one-second
// prescaler and two BCD counters (seconds, minutes); counts up in stopwatch
// mode or down in timer mode, with manual presets while stopped.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   en                  global enable (softrst still acts when low)
//   start_p, stop_p     one-cycle start / stop pulses
//   softrst             soft-reset level: clears time, returns to IDLE
//   inc_min_p, inc_sec_p  one-cycle preset pulses (IDLE/PAUSE only)
//   inc_sw              direction latched at start: 0 up, 1 down
//   min_tens..sec_ones  registered BCD digits of mm:ss
//   running, done       registered state flags (RUN, DONE)
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int MAX_MIN       = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       softrst,
  input  logic       inc_min_p,
  input  logic       inc_sec_p,
  input  logic       inc_sw,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  // Per-cycle actions decided by the FSM.
  logic clr_all;
  logic preset_sec, preset_min;
  logic tick_up, tick_dn;

  // Counter controls and flags.
  logic sec_inc, sec_dec, sec_carry, sec_borrow;
  logic min_inc, min_dec, min_carry, min_borrow;
  logic [1:0] unused_min_flags;

  logic time_zero, time_one;

  assign time_zero = (min_tens == BCD_ZERO) && (min_ones == BCD_ZERO) &&
                     (sec_tens == BCD_ZERO) && (sec_ones == BCD_ZERO);
  assign time_one  = (min_tens == BCD_ZERO) && (min_ones == BCD_ZERO) &&
                     (sec_tens == BCD_ZERO) && (sec_ones == BCD_ONE);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    presc_d    = presc_q;
    clr_all    = 1'b0;
    preset_sec = 1'b0;
    preset_min = 1'b0;
    tick_up    = 1'b0;
    tick_dn    = 1'b0;

    if (softrst) begin
      state_d = ST_IDLE;
      presc_d = '0;
      clr_all = 1'b1;
    end else if (en) begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: begin
          // stop_p outranks start_p and the presets, so a stop pulse here
          // simply leaves everything as it is.
          if (!stop_p && start_p) begin
            // A countdown from 00:00 would finish instantly; refuse it.
            if (!(inc_sw && time_zero)) begin
              state_d = ST_RUN;
              dir_d   = inc_sw;
              // A fresh start begins a full second; a resume keeps the
              // partial second that was in progress at the stop.
              if (state_q == ST_IDLE) presc_d = '0;
            end
          end else if (!stop_p) begin
            preset_sec = inc_sec_p;
            preset_min = inc_min_p;
          end
        end
        ST_RUN: begin
          if (stop_p) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (dir_q) begin
              tick_dn = 1'b1;
              if (time_one) state_d = ST_DONE;
            end else begin
              tick_up = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          // DONE: only softrst or rst leave this state.
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // Seconds ripple into minutes only on timed ticks; a manual second preset
  // wraps 59->00 without touching the minutes.
  assign sec_inc = preset_sec | tick_up;
  assign sec_dec = tick_dn;
  assign min_inc = preset_min | (tick_up & sec_carry);
  assign min_dec = tick_dn & sec_borrow;

  assign unused_min_flags = {min_carry, min_borrow};

  bcd2_counter #(
    .MOD(SEC_MOD)
  ) u_sec (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_all),
    .inc       (sec_inc),
    .dec       (sec_dec),
    .tens      (sec_tens),
    .ones      (sec_ones),
    .carry_out (sec_carry),
    .borrow_out(sec_borrow)
  );

  bcd2_counter #(
    .MOD(MAX_MIN + 1)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_all),
    .inc       (min_inc),
    .dec       (min_dec),
    .tens      (min_tens),
    .ones      (min_ones),
    .carry_out (min_carry),
    .borrow_out(min_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst, en, start_p, stop_p, softrst, inc_min_p, inc_sec_p, inc_sw;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, done;
  logic [15:0] time_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign time_v = {min_tens, min_ones, sec_tens, sec_ones};

  stopwatch_core #(
    .TICKS_PER_SEC(4),
    .MAX_MIN      (99)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start_p  (start_p),
    .stop_p   (stop_p),
    .softrst  (softrst),
    .inc_min_p(inc_min_p),
    .inc_sec_p(inc_sec_p),
    .inc_sw   (inc_sw),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .done     (done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic p_start, input logic p_stop,
                       input logic p_min, input logic p_sec);
    start_p   = p_start;
    stop_p    = p_stop;
    inc_min_p = p_min;
    inc_sec_p = p_sec;
    cyc(1);
    start_p   = 1'b0;
    stop_p    = 1'b0;
    inc_min_p = 1'b0;
    inc_sec_p = 1'b0;
  endtask

  task automatic do_softrst;
    softrst = 1'b1;
    cyc(1);
    softrst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; start_p = 1'b0; stop_p = 1'b0; softrst = 1'b0;
    inc_min_p = 1'b0; inc_sec_p = 1'b0; inc_sw = 1'b0;
    cyc(2);
    n_cmp++;
    if ({time_v, running, done} !== {16'h0000, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_state: got %h r%b d%b want 0000 r0 d0", time_v, running, done);
    end
    rst = 1'b0;
    cyc(1);
    // Preset 01:23 and start, then hit rst between clock edges.
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 23; i++) pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    cyc(2);
    n_cmp++;
    if ({time_v, running} !== {16'h0123, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_rst_run: got %h r%b want 0123 r1", time_v, running);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({time_v, running, done} !== {16'h0000, 2'b00}) begin
      n_bad++;
      $display("FAIL async_rst: got %h r%b d%b want 0000 r0 d0", time_v, running, done);
    end
    cyc(2);
    rst = 1'b0;
    cyc(3);
    n_cmp++;
    if ({time_v, running, done} !== {16'h0000, 2'b00}) begin
      n_bad++;
      $display("FAIL post_rst_idle: got %h r%b d%b want 0000 r0 d0", time_v, running, done);
    end
  endtask

  task automatic test_presets;
    do_softrst();
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) pulse(0, 0, 0, 1);
    n_cmp++;
    if (time_v !== 16'h0203) begin
      n_bad++;
      $display("FAIL preset_0203: got %h want 0203", time_v);
    end
    for (int i = 0; i < 56; i++) pulse(0, 0, 0, 1);
    n_cmp++;
    if (time_v !== 16'h0259) begin
      n_bad++;
      $display("FAIL preset_0259: got %h want 0259", time_v);
    end
    pulse(0, 0, 0, 1);
    n_cmp++;
    if (time_v !== 16'h0200) begin
      n_bad++;
      $display("FAIL sec_wrap_no_carry: got %h want 0200", time_v);
    end
    pulse(0, 0, 1, 1);
    n_cmp++;
    if (time_v !== 16'h0301) begin
      n_bad++;
      $display("FAIL both_incs: got %h want 0301", time_v);
    end
  endtask

  task automatic test_count_up_pause;
    do_softrst();
    inc_sw = 1'b0;
    pulse(1, 0, 0, 0);
    cyc(244);
    n_cmp++;
    if ({time_v, running} !== {16'h0101, 1'b1}) begin
      n_bad++;
      $display("FAIL up_244: got %h r%b want 0101 r1", time_v, running);
    end
    cyc(2);
    pulse(0, 1, 0, 0);
    n_cmp++;
    if ({time_v, running} !== {16'h0101, 1'b0}) begin
      n_bad++;
      $display("FAIL stop: got %h r%b want 0101 r0", time_v, running);
    end
    cyc(40);
    n_cmp++;
    if (time_v !== 16'h0101) begin
      n_bad++;
      $display("FAIL pause_hold: got %h want 0101", time_v);
    end
    // Prescaler held at 2: resume edge keeps 2, then 3, then the tick.
    pulse(1, 0, 0, 0);
    cyc(1);
    n_cmp++;
    if ({time_v, running} !== {16'h0101, 1'b1}) begin
      n_bad++;
      $display("FAIL resume_pre_tick: got %h r%b want 0101 r1", time_v, running);
    end
    cyc(1);
    n_cmp++;
    if (time_v !== 16'h0102) begin
      n_bad++;
      $display("FAIL resume_tick: got %h want 0102", time_v);
    end
  endtask

  task automatic test_countdown_done;
    do_softrst();
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    inc_sw = 1'b1;
    pulse(1, 0, 0, 0);
    cyc(7);
    n_cmp++;
    if ({time_v, running, done} !== {16'h0001, 2'b10}) begin
      n_bad++;
      $display("FAIL down_0001: got %h r%b d%b want 0001 r1 d0", time_v, running, done);
    end
    cyc(1);
    n_cmp++;
    if ({time_v, running, done} !== {16'h0000, 2'b01}) begin
      n_bad++;
      $display("FAIL done_reached: got %h r%b d%b want 0000 r0 d1", time_v, running, done);
    end
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 1);
    cyc(8);
    n_cmp++;
    if ({time_v, running, done} !== {16'h0000, 2'b01}) begin
      n_bad++;
      $display("FAIL done_sticky: got %h r%b d%b want 0000 r0 d1", time_v, running, done);
    end
    do_softrst();
    n_cmp++;
    if ({running, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL done_softrst: got r%b d%b want r0 d0", running, done);
    end
    pulse(1, 0, 0, 0);
    cyc(4);
    n_cmp++;
    if ({time_v, running} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL down_zero_start: got %h r%b want 0000 r0", time_v, running);
    end
  endtask

  task automatic test_priority_softrst;
    do_softrst();
    inc_sw = 1'b0;
    for (int i = 0; i < 45; i++) pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    cyc(2);
    pulse(0, 0, 0, 1);
    n_cmp++;
    if ({time_v, running} !== {16'h0045, 1'b1}) begin
      n_bad++;
      $display("FAIL inc_in_run: got %h r%b want 0045 r1", time_v, running);
    end
    softrst = 1'b1;
    cyc(1);
    n_cmp++;
    if ({time_v, running} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL softrst_run: got %h r%b want 0000 r0", time_v, running);
    end
    pulse(1, 0, 1, 1);
    softrst = 1'b0;
    n_cmp++;
    if ({time_v, running} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL softrst_held: got %h r%b want 0000 r0", time_v, running);
    end
    pulse(1, 0, 0, 0);
    cyc(1);
    pulse(1, 1, 0, 0);
    n_cmp++;
    if (running !== 1'b0) begin
      n_bad++;
      $display("FAIL start_stop_run: got r%b want r0", running);
    end
    pulse(1, 1, 0, 0);
    n_cmp++;
    if (running !== 1'b0) begin
      n_bad++;
      $display("FAIL start_stop_pause: got r%b want r0", running);
    end
    pulse(1, 0, 0, 0);
    n_cmp++;
    if (running !== 1'b1) begin
      n_bad++;
      $display("FAIL resume_after: got r%b want r1", running);
    end
  endtask

  task automatic test_wrap_enable;
    do_softrst();
    inc_sw = 1'b0;
    for (int i = 0; i < 99; i++) pulse(0, 0, 1, 0);
    for (int i = 0; i < 59; i++) pulse(0, 0, 0, 1);
    n_cmp++;
    if (time_v !== 16'h9959) begin
      n_bad++;
      $display("FAIL preset_9959: got %h want 9959", time_v);
    end
    pulse(1, 0, 0, 0);
    cyc(4);
    n_cmp++;
    if ({time_v, running} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL max_wrap: got %h r%b want 0000 r1", time_v, running);
    end
    cyc(2);
    en = 1'b0;
    cyc(5);
    pulse(0, 1, 0, 0);
    cyc(5);
    pulse(1, 0, 1, 1);
    cyc(8);
    n_cmp++;
    if ({time_v, running} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL en_freeze: got %h r%b want 0000 r1", time_v, running);
    end
    en = 1'b1;
    cyc(1);
    n_cmp++;
    if (time_v !== 16'h0000) begin
      n_bad++;
      $display("FAIL en_presc_hold: got %h want 0000", time_v);
    end
    cyc(1);
    n_cmp++;
    if (time_v !== 16'h0001) begin
      n_bad++;
      $display("FAIL en_resume_tick: got %h want 0001", time_v);
    end
  endtask

  initial begin
    test_reset();
    test_presets();
    test_count_up_pause();
    test_countdown_done();
    test_priority_softrst();
    test_wrap_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
